// File: rtl/pc_stack_pkg.sv
// Shared types and constants for the nibble-serial program-counter stack.
package pc_stack_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_JUMP  = 3'd2,
    OP_JPAGE = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5,
    OP_CLR   = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    INCR = 1'b1
  } state_t;

endpackage

// File: rtl/pc_stack_nibble_incrementer.sv
// Single 4-bit incrementer shared by all nibbles of the serial PC increment.
module nibble_incrementer
  import pc_stack_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, nib} + (NIB_W + 1)'(cin);

endmodule

// File: rtl/pc_stack_nibble.sv
// Program counter and return-address stack with nibble-serial increment
// and selectable wrap/trap behaviour on stack overflow and underflow.
module pc_stack_nibble
  import pc_stack_pkg::*;
#(
  parameter int unsigned ADDR_NIBBLES = 3,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned OVF_MODE     = 0,
  localparam int unsigned AW = NIB_W * ADDR_NIBBLES,
  localparam int unsigned LW = $clog2(DEPTH),
  localparam int unsigned SW = (ADDR_NIBBLES > 1) ? $clog2(ADDR_NIBBLES) : 1
) (
  input  logic          sysclk,
  input  logic          poc_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [SW-1:0] rd_sel,
  output logic [3:0]    rd_nib,
  output logic [AW-1:0] pc,
  output logic [LW-1:0] level,
  output logic [LW-1:0] used,
  output logic          err,
  output logic          pc_wrap
);

  localparam logic [AW-1:0] PAGE_MASK = AW'(8'hFF);
  localparam logic [LW-1:0] FULL      = LW'(DEPTH - 1);
  localparam logic [SW-1:0] LAST      = SW'(ADDR_NIBBLES - 1);

  state_t        state, state_nx;
  logic [AW-1:0] stack [DEPTH];
  logic [AW-1:0] work, work_nx;
  logic          carry, carry_nx;
  logic [SW-1:0] k, k_nx;
  logic [LW-1:0] level_nx, used_nx;
  logic          err_nx, wrap_nx;
  logic          wr_en, clr;
  logic [LW-1:0] wr_idx;
  logic [AW-1:0] wr_data;
  logic [NIB_W-1:0] inc_sum;
  logic          inc_cout;

  assign pc        = stack[level];
  assign cmd_ready = (state == IDLE);

  nibble_incrementer u_inc (
    .nib  (work[k*NIB_W +: NIB_W]),
    .cin  (carry),
    .sum  (inc_sum),
    .cout (inc_cout)
  );

  // Out-of-range nibble indices fall through to zero.
  always_comb begin
    rd_nib = '0;
    for (int i = 0; i < int'(ADDR_NIBBLES); i++) begin
      if (SW'(i) == rd_sel) rd_nib = pc[i*NIB_W +: NIB_W];
    end
  end

  always_comb begin
    state_nx = state;
    level_nx = level;
    used_nx  = used;
    work_nx  = work;
    carry_nx = carry;
    k_nx     = k;
    err_nx   = 1'b0;
    wrap_nx  = 1'b0;
    wr_en    = 1'b0;
    clr      = 1'b0;
    wr_idx   = level;
    wr_data  = work;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_INC: begin
              state_nx = INCR;
              work_nx  = pc;
              carry_nx = 1'b1;
              k_nx     = '0;
            end
            OP_JUMP: begin
              wr_en   = 1'b1;
              wr_data = cmd_addr;
            end
            OP_JPAGE: begin
              wr_en   = 1'b1;
              wr_data = (pc & ~PAGE_MASK) | (cmd_addr & PAGE_MASK);
            end
            OP_CALL: begin
              if (used != FULL || OVF_MODE == 0) begin
                level_nx = level + LW'(1);
                if (used != FULL) used_nx = used + LW'(1);
                wr_en   = 1'b1;
                wr_idx  = level_nx;
                wr_data = cmd_addr;
              end else begin
                err_nx = 1'b1;
              end
            end
            OP_RET: begin
              if (used != '0 || OVF_MODE == 0) begin
                level_nx = level - LW'(1);
                if (used != '0) used_nx = used - LW'(1);
              end else begin
                err_nx = 1'b1;
              end
            end
            OP_CLR: begin
              clr      = 1'b1;
              level_nx = '0;
              used_nx  = '0;
            end
            default: ;
          endcase
        end
      end
      INCR: begin
        // pc keeps its old value until the full working copy is committed.
        work_nx[k*NIB_W +: NIB_W] = inc_sum;
        carry_nx = inc_cout;
        if (k == LAST) begin
          state_nx = IDLE;
          wr_en    = 1'b1;
          wr_data  = work_nx;
          wrap_nx  = inc_cout;
        end else begin
          k_nx = k + SW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      state   <= IDLE;
      level   <= '0;
      used    <= '0;
      work    <= '0;
      carry   <= 1'b0;
      k       <= '0;
      err     <= 1'b0;
      pc_wrap <= 1'b0;
    end else begin
      state   <= state_nx;
      level   <= level_nx;
      used    <= used_nx;
      work    <= work_nx;
      carry   <= carry_nx;
      k       <= k_nx;
      err     <= err_nx;
      pc_wrap <= wrap_nx;
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stack[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) stack[i] <= '0;
    end else if (wr_en) begin
      stack[wr_idx] <= wr_data;
    end
  end

endmodule

// File: doc/pc_stack_nibble.md
# pc_stack_nibble

Parametrised program-counter and return-address stack for the MCS-4 core family: a generalised successor to the 4004's fixed 12-bit, 4-level pointer array. The active level is selected by a level pointer. It supports jump, page-jump, call, return and stack clear as single-cycle operations. Increment is nibble-serial through one 4-bit incrementer, matching the 4-bit datapath. A configurable overflow mode either wraps silently (4004-compatible) or traps with an error pulse.

## Interface
- ADDR_NIBBLES, 3: address width in nibbles; legal range 2..8; address width AW = 4*ADDR_NIBBLES.
- DEPTH, 4: number of address levels; power of 2, range 2..16; LW = log2(DEPTH).
- OVF_MODE, 0: 0 = wrap (4004 behaviour), 1 = trap.
- sysclk  in  1  single FPGA clock; all state changes on its rising edge.
- poc_n  in  1  power-on clear; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  operation code; see Operation.
- cmd_addr  in  AW  target address for JUMP/JPAGE/CALL.
- rd_sel  in  max(1,log2(ADDR_NIBBLES))  nibble index for the read port.
- rd_nib  out  4  combinational nibble rd_sel of pc; out-of-range index reads 0.
- pc  out  AW  current address, taken from the active level.
- level  out  LW  active level pointer.
- used  out  LW  number of saved return levels, 0..DEPTH-1.
- err  out  1  one-cycle pulse when a trap-mode overflow or underflow is rejected.
- pc_wrap  out  1  one-cycle pulse when INC carries out of the top nibble.

## Operation
- A command is accepted on a rising edge where cmd_valid & cmd_ready are both high. A command presented while busy is not lost: cmd_valid is held by the source.
- Opcodes:
  - 0 NOP.
  - 1 INC: active level += 1 modulo 2^AW.
  - 2 JUMP: active level = cmd_addr.
  - 3 JPAGE: low 2 nibbles come from cmd_addr; upper nibbles are kept. With ADDR_NIBBLES = 2, JPAGE is identical to JUMP.
  - 4 CALL: level += 1, then the new active level = cmd_addr. The previous level keeps its return address.
  - 5 RET: level -= 1.
  - 6 CLR: all levels = 0, level = 0, used = 0.
  - 7 reserved; treated as NOP with no err.
- CALL when used < DEPTH-1: used += 1.
- CALL when used == DEPTH-1:
  - Wrap mode: level wraps modulo DEPTH and overwrites the oldest entry; used stays DEPTH-1; no err.
  - Trap mode: nothing changes; err pulses.
- RET when used > 0: used -= 1.
- RET when used == 0:
  - Wrap mode: level decrements modulo DEPTH; used stays 0; no err.
  - Trap mode: nothing changes; err pulses.
- FSM states:
  - IDLE: cmd_ready = 1. INC moves to INCR with nibble index k = 0 and carry = 1. All other ops complete in IDLE.
  - INCR: cmd_ready = 0. Each cycle, nibble k of a working copy is replaced by nibble + carry, and the carry is registered. When k == ADDR_NIBBLES-1, the working copy is written to the active level, pc_wrap is set to the final carry, and the state returns to IDLE.
- During INCR, pc shows the old value; the update is atomic at completion.
- Reset values (asynchronous, while poc_n = 0): all levels 0, pc 0, level 0, used 0, state IDLE, cmd_ready 1, err 0, pc_wrap 0, working copy and carry 0.
- poc_n asserted mid-INCR aborts the increment; state after release is the reset state.

## Timing
- Single-cycle ops accepted at edge T: pc, level, used and err are updated at edge T; err is high for the cycle after T only.
- INC accepted at edge T:
  - cmd_ready is low from after T until edge T+ADDR_NIBBLES.
  - pc and pc_wrap update at edge T+ADDR_NIBBLES.
  - cmd_ready is high again in the cycle following T+ADDR_NIBBLES, so the next command can be accepted at T+ADDR_NIBBLES+1.
- INC latency is fixed at ADDR_NIBBLES cycles; there is no early exit when the carry clears.
- rd_nib is combinational from pc and rd_sel; no latency.
- Release of poc_n is synchronised by the system; the block needs no internal synchroniser.

## Structure
- Package pc_stack_pkg holds:
  - the op_t enum (NOP, INC, JUMP, JPAGE, CALL, RET, CLR, RSVD);
  - the state_t enum (IDLE, INCR);
  - the constant NIB_W = 4.
- One sub-module, nibble_incrementer: inputs 4-bit nibble and carry-in; outputs 4-bit sum and carry-out.
- Level storage is a DEPTH x AW register array; no RAM inference required.

## Test plan
1. Reset, then INC with ADDR_NIBBLES=3 -> cmd_ready is low for 3 cycles, pc = 0x001, pc_wrap = 0.
2. JUMP 0xFFF, then INC -> pc = 0x000, pc_wrap pulses once, level unchanged.
3. JUMP 0x2A5, then JPAGE 0x3C7 -> pc = 0x2C7.
4. Wrap mode, DEPTH=4:
   - Sequence: JUMP 0x100, then CALL 0x200, CALL 0x300, CALL 0x400 -> used = 3.
   - A further CALL 0x500 -> level wraps to 0, used = 3, err = 0, and the oldest entry now holds 0x500.
   - Four RETs -> pc visits 0x400, 0x300, 0x200, 0x500.
5. Trap mode: RET at used = 0 -> err pulses for exactly one cycle; pc, level and used are unchanged. CALL at used = 3 -> same behaviour.
6. Start INC from pc = 0x0FF and assert poc_n low after 2 cycles -> all outputs take reset values immediately. After release, one INC gives pc = 0x001.
